// File: rtl/sub4_serial.sv
// sub4_serial: bit-serial unsigned subtractor, diff = a - b, LSB first.
// A start/done handshake accepts one operation in IDLE. WIDTH clocks of SHIFT
// follow, then a single DONE clock that pulses done with the new result.
module sub4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  // The counter is at least one bit wide, so WIDTH=1 still has a legal counter.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             br_reg;
  logic             br_next;
  logic             d_bit;
  logic [CW-1:0]    cnt_reg;

  // One full-subtractor slice acts on the current LSBs of the operand shift registers.
  always_comb begin
    d_bit   = a_reg[0] ^ b_reg[0] ^ br_reg;
    br_next = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);
  end

  // The result register fills from the MSB side. After WIDTH shifts, bit 0
  // holds the first difference bit that was computed.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_res
      if (gi == WIDTH - 1) begin : g_top
        assign res_next[gi] = d_bit;
      end else begin : g_mid
        assign res_next[gi] = res_reg[gi+1];
      end
    end
  endgenerate

  // Control FSM and datapath. diff and bout load only on the final SHIFT edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            res_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          res_reg <= res_next;
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          br_reg  <= br_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_BIT) begin
            diff      <= res_next;
            bout      <= br_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
